icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the datapath instruction-fetch port (imemREN/imemaddr/ihit/imemload) and the memory controller instruction port.
- Hits return in the same cycle.
- Misses fill a 2-word block from memory through a small FSM, then hit on the cycle after the fill completes.
- Replaces the direct datapath-to-RAM instruction path in the single-cycle and pipelined cores.

---
 rtl/icache_direct_pkg.sv | 27 ++
 rtl/icache_if.sv | 15 +
 rtl/icache_direct.sv | 116 +++++++++++
 tb/tb_icache_direct.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout, fill FSM.
package icache_direct_pkg;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 32 - 3 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic                    blkoff;
        logic [1:0]              bytoff;
    } icache_addr_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [1:0][31:0]        data;
    } icache_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL0,
        FILL1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Port bundle between datapath fetch stage, instruction cache and memory controller.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    modport cache (input imemREN, imemaddr, iload, iwait, output ihit, imemload, iREN, iaddr);
    modport dp    (output imemREN, imemaddr, input ihit, imemload);
    modport tb    (output imemREN, imemaddr, iload, iwait, input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a 2-word block fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int unsigned SETS        = ICACHE_SETS,
    parameter int unsigned BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    icache_state_t           state_q;
    icache_frame_t           frame_q [SETS];
    logic [ICACHE_TAG_W-1:0] fill_tag_q;
    logic [ICACHE_IDX_W-1:0] fill_idx_q;
    logic [31:0]             word0_q;
    logic                    iren_q;
    logic [31:0]             iaddr_q;

    icache_addr_t  req;
    icache_frame_t sel;
    logic          hit_raw;
    logic          start_fill;
    logic          unused_bytoff;

    assign req           = icache_addr_t'(imemaddr);
    assign sel           = frame_q[req.idx];
    assign unused_bytoff = ^req.bytoff;

    // Hits are suppressed while a fill is outstanding.
    assign hit_raw    = sel.valid && (sel.tag == req.tag);
    assign ihit       = imemREN && hit_raw && (state_q == IDLE);
    assign imemload   = ihit ? sel.data[req.blkoff] : 32'h0;
    assign start_fill = (state_q == IDLE) && imemREN && !hit_raw;
    assign iREN       = iren_q;
    assign iaddr      = iaddr_q;

    always_ff @(posedge CLK) begin
        assert (SETS == ICACHE_SETS && BLOCK_WORDS == 2)
        else $error("icache_direct: unsupported geometry");
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            word0_q    <= '0;
            iren_q     <= 1'b0;
            iaddr_q    <= '0;
            for (int i = 0; i < int'(SETS); i++) begin
                frame_q[i].valid <= 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_fill) begin
                        state_q    <= FILL0;
                        fill_tag_q <= req.tag;
                        fill_idx_q <= req.idx;
                        iren_q     <= 1'b1;
                        iaddr_q    <= {req.tag, req.idx, 1'b0, 2'b00};
                    end
                end
                FILL0: begin
                    if (!iwait) begin
                        state_q <= FILL1;
                        word0_q <= iload;
                        iaddr_q <= {fill_tag_q, fill_idx_q, 1'b1, 2'b00};
                    end
                end
                FILL1: begin
                    if (!iwait) begin
                        state_q             <= IDLE;
                        frame_q[fill_idx_q] <= '{valid: 1'b1, tag: fill_tag_q,
                                                 data: {iload, word0_q}};
                        iren_q              <= 1'b0;
                        iaddr_q             <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a scoreboard of expected fetch data.
// Covers ICACHE_STATS_EN counters when that macro is defined.
module tb_icache_direct;

    logic clk;
    logic rst;
    icache_if bus ();
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb [$];

    icache_direct dut (
        .CLK      (clk),
        .RST      (rst),
        .imemREN  (bus.imemREN),
        .imemaddr (bus.imemaddr),
        .ihit     (bus.ihit),
        .imemload (bus.imemload),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iload    (bus.iload),
        .iwait    (bus.iwait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hAAAA_0000;
            32'h0000_0004: return 32'hBBBB_1111;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    always_comb bus.iload = mem_word(bus.iaddr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] addr);
        sb.push_back(mem_word({addr[31:2], 2'b00}));
    endtask

    // Consume one scoreboard entry against the current cycle's output.
    task automatic expect_hit(input string tag);
        logic [31:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check({tag, " ihit"}, {31'b0, bus.ihit}, 32'd1);
        check({tag, " data"}, bus.imemload, exp);
    endtask

    task automatic fetch(input logic [31:0] addr, input int exp_lat, input string tag);
        int lat;
        bit done;
        push(addr);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        #1;
        lat  = 0;
        done = 1'b0;
        while (!done && lat <= 50) begin
            if (bus.ihit) begin
                expect_hit(tag);
                check({tag, " latency"}, 32'(lat), 32'(exp_lat));
                done = 1'b1;
            end else begin
                step();
                lat++;
            end
        end
        if (!done) begin
            void'(sb.pop_front());
            check({tag, " timeout"}, {31'b0, bus.ihit}, 32'd1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.iwait    = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst ihit", {31'b0, bus.ihit}, 32'd0);
        check("rst imemload", bus.imemload, 32'h0);
        check("rst iREN", {31'b0, bus.iREN}, 32'd0);
        check("rst iaddr", bus.iaddr, 32'h0);

        // Cold miss on word 1 of block 0
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0004;
        push(32'h0000_0004);
        #1;
        check("cold c0 ihit", {31'b0, bus.ihit}, 32'd0);
        step();
        check("cold fill0 iREN", {31'b0, bus.iREN}, 32'd1);
        check("cold fill0 iaddr", bus.iaddr, 32'h0);
        check("cold fill0 ihit", {31'b0, bus.ihit}, 32'd0);
        step();
        check("cold fill1 iaddr", bus.iaddr, 32'h4);
        step();
        expect_hit("cold c3");

        // Same-block hit
        bus.imemaddr = 32'h0000_0000;
        push(32'h0000_0000);
        #1;
        expect_hit("same blk");
        check("same blk iREN", {31'b0, bus.iREN}, 32'd0);

        // Conflict eviction at index 0
        fetch(32'h0000_0080, 3, "evict");
        fetch(32'h0000_0000, 3, "refetch");
        fetch(32'h0000_0004, 0, "reuse");

        // Wait states: 3 stalls in FILL0, 2 in FILL1
        bus.imemaddr = 32'h0000_0108;
        bus.iwait    = 1'b1;
        push(32'h0000_0108);
        #1;
        check("wait c0 ihit", {31'b0, bus.ihit}, 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            check("wait fill0 iaddr", bus.iaddr, 32'h108);
            check("wait fill0 ihit", {31'b0, bus.ihit}, 32'd0);
            step();
        end
        bus.iwait = 1'b0;
        #1;
        check("wait fill0 last iaddr", bus.iaddr, 32'h108);
        step();
        bus.iwait = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("wait fill1 iaddr", bus.iaddr, 32'h10C);
            check("wait fill1 iREN", {31'b0, bus.iREN}, 32'd1);
            step();
        end
        bus.iwait = 1'b0;
        #1;
        check("wait fill1 last iaddr", bus.iaddr, 32'h10C);
        step();
        expect_hit("wait done");

        // Address change mid-fill
        bus.imemaddr = 32'h0000_0200;
        #1;
        step();
        check("mid fill0 iaddr", bus.iaddr, 32'h200);
        bus.imemaddr = 32'h0000_0040;
        push(32'h0000_0040);
        #1;
        check("mid fill0 ihit", {31'b0, bus.ihit}, 32'd0);
        step();
        check("mid fill1 iaddr", bus.iaddr, 32'h204);
        step();
        check("mid idle ihit", {31'b0, bus.ihit}, 32'd0);
        check("mid idle iREN", {31'b0, bus.iREN}, 32'd0);
        step();
        check("mid refill iaddr", bus.iaddr, 32'h40);
        step();
        step();
        expect_hit("mid new");
        fetch(32'h0000_0200, 0, "mid orig");

        // Reset during FILL1 aborts the fill
        bus.imemaddr = 32'h0000_0300;
        #1;
        step();
        step();
        check("rstfill fill1 iaddr", bus.iaddr, 32'h304);
        rst = 1'b1;
        step();
        check("rstfill iREN", {31'b0, bus.iREN}, 32'd0);
        check("rstfill iaddr", bus.iaddr, 32'h0);
        rst = 1'b0;
        fetch(32'h0000_0300, 3, "post rst");
        fetch(32'h0000_0040, 3, "rst cleared");

`ifdef ICACHE_STATS_EN
        bus.imemREN = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("stats rst hits", hit_count, 32'd0);
        check("stats rst misses", miss_count, 32'd0);
        fetch(32'h0000_0500, 3, "stats");
        for (int k = 0; k < 4; k++) step();
        bus.imemREN = 1'b0;
        step();
        check("stats hits", hit_count, 32'd4);
        check("stats misses", miss_count, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stats clr hits", hit_count, 32'd0);
        check("stats clr misses", miss_count, 32'd0);
`endif

        check("sb drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
